// File: rtl/serializer_piso_pkg.sv
// -----------------------------------------------------------------------------
// serializer_piso_pkg
// Shared definitions for the serial-path blocks: the serializer FSM state
// encoding and the default parallel word width.
// -----------------------------------------------------------------------------
package serializer_piso_pkg;

    // Encoding is fixed so other serial-path blocks and debug tools agree on it.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serializer_piso.sv
// -----------------------------------------------------------------------------
// serializer_piso
// Parallel-in / serial-out converter with a valid/ready load handshake.
// A word accepted at a rising edge has its first bit on sout straight after
// that edge. The next word can be accepted on the last-bit edge, so a
// continuous stream of words has no gap between them.
//
// Parameters
//   WIDTH      parallel word width, 2..32
//   MSB_FIRST  1: send din[WIDTH-1] first, 0: send din[0] first
//
// Ports
//   clock       rising-edge clock
//   clear       asynchronous active-low reset
//   din         parallel word, sampled only on a handshake edge
//   load_valid  upstream has a word on din
//   load_ready  block accepts din this cycle
//   sout        registered serial bit
//   sout_valid  sout carries a data bit
//   sout_last   sout carries the final bit of the current word
// -----------------------------------------------------------------------------
module serializer_piso
    import serializer_piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;      // index of the bit currently on sout
    logic [WIDTH-1:0]   sreg;     // bits still to be sent, next one at the head
    logic               at_last;
    logic               handshake;

    // Bit that leaves first, depending on the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit removed, the next bit moved to the head.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign at_last = (state == SHIFT) && (cnt == LAST_IDX);

    // NOTE: load_ready depends only on registered state, never on load_valid,
    // so an upstream that derives load_valid from load_ready cannot close a
    // combinational loop through this block.
    assign load_ready = (state == IDLE) || at_last;
    assign handshake  = load_valid && load_ready;

    // NOTE: every register here, the reset branch included, uses non-blocking
    // assignment so all state updates together at the edge and simulation
    // matches the synthesized flops regardless of block ordering.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
        end else if (handshake) begin
            // Covers both IDLE->SHIFT and the zero-gap reload on the last bit.
            state      <= SHIFT;
            cnt        <= '0;
            sout       <= head_bit(din);
            sreg       <= drop_head(din);
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
        end else if (state == SHIFT) begin
            if (at_last) begin
                // Counter holds at WIDTH-1; it is reloaded on the next handshake.
                state      <= IDLE;
                sout       <= 1'b0;
                sout_valid <= 1'b0;
                sout_last  <= 1'b0;
            end else begin
                cnt        <= cnt + 1'b1;
                sout       <= head_bit(sreg);
                sreg       <= drop_head(sreg);
                sout_last  <= (cnt == LAST_IDX - 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_serializer_piso.sv
// -----------------------------------------------------------------------------
// tb_serializer_piso
// Self-checking bench for serializer_piso. Two instances: WIDTH=8 MSB-first
// (main) and WIDTH=8 LSB-first. Expected streams come from the bit-order rule
// applied to each word; a 4-stage serial register downstream of the MSB-first
// instance checks the end-to-end path.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serializer_piso;

    logic       clock = 1'b0;
    logic       clear;
    logic [7:0] din_m, din_l;
    logic       lv_m, lv_l;
    logic       rdy_m, rdy_l, so_m, so_l, sv_m, sv_l, sl_m, sl_l;
    logic [3:0] chain;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clock), .clear(clear), .din(din_m), .load_valid(lv_m),
        .load_ready(rdy_m), .sout(so_m), .sout_valid(sv_m), .sout_last(sl_m)
    );

    serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .clear(clear), .din(din_l), .load_valid(lv_l),
        .load_ready(rdy_l), .sout(so_l), .sout_valid(sv_l), .sout_last(sl_l)
    );

    // Downstream serial consumer: chain[3] is the oldest bit.
    always @(posedge clock or negedge clear) begin
        if (!clear) chain <= 4'b0;
        else        chain <= {chain[2:0], so_m};
    end

    // Reference: bit i of the serialized word.
    function automatic logic model_bit(input logic [7:0] w, input int i, input bit msb);
        return msb ? w[7 - i] : w[i];
    endfunction

    // Present word on the MSB-first instance and wait (bounded) for the
    // handshake edge. Returns at the falling edge of cycle 0 of the word.
    task automatic handshake_m(input logic [7:0] word);
        int t;
        din_m = word;
        lv_m  = 1'b1;
        t = 0;
        while (rdy_m !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (rdy_m !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_timeout: load_ready=%b required 1", rdy_m);
        end
        @(posedge clock);
        @(negedge clock);
        lv_m = 1'b0;
    endtask

    // Check all 8 bits of word; starts at cycle 0, ends at cycle 7.
    task automatic expect_word_m(input logic [7:0] word, input string tag);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (so_m !== model_bit(word, i, 1'b1) || sv_m !== 1'b1 ||
                sl_m !== (i == 7) || rdy_m !== (i == 7)) begin
                n_fail++;
                $display("FAIL %s bit%0d: sout/valid/last/ready=%b%b%b%b required %b1%b%b",
                         tag, i, so_m, sv_m, sl_m, rdy_m,
                         model_bit(word, i, 1'b1), (i == 7), (i == 7));
            end
            if (i < 7) @(negedge clock);
        end
    endtask

    // Advance one cycle and check the idle output state.
    task automatic expect_idle_m(input string tag);
        @(negedge clock);
        n_checks++;
        if (so_m !== 1'b0 || sv_m !== 1'b0 || sl_m !== 1'b0 || rdy_m !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: sout/valid/last/ready=%b%b%b%b required 0001",
                     tag, so_m, sv_m, sl_m, rdy_m);
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        din_m = 8'h00; lv_m = 1'b0;
        din_l = 8'h00; lv_l = 1'b0;
        #1;
        n_checks++;
        if ({so_m, sv_m, sl_m, rdy_m} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_msb: sout/valid/last/ready=%b%b%b%b required 0001",
                     so_m, sv_m, sl_m, rdy_m);
        end
        n_checks++;
        if ({so_l, sv_l, sl_l, rdy_l} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_lsb: sout/valid/last/ready=%b%b%b%b required 0001",
                     so_l, sv_l, sl_l, rdy_l);
        end
        // Offered words are ignored while clear is low.
        din_m = 8'hFF; lv_m = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({so_m, sv_m, sl_m, rdy_m} !== 4'b0001 || chain !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_hold: sout/valid/last/ready=%b%b%b%b chain=%b required 0001 0000",
                     so_m, sv_m, sl_m, rdy_m, chain);
        end
        lv_m  = 1'b0;
        clear = 1'b1;
    endtask

    task automatic test_msb_a5();
        handshake_m(8'hA5);
        expect_word_m(8'hA5, "msb_a5");
        expect_idle_m("msb_a5");
    endtask

    task automatic test_lsb_a5();
        int n_valid;
        n_valid = 0;
        din_l = 8'hA5;
        lv_l  = 1'b1;
        n_checks++;
        if (rdy_l !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_ready: load_ready=%b required 1", rdy_l);
        end
        @(posedge clock);
        @(negedge clock);
        lv_l = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (sv_l === 1'b1) n_valid++;
            n_checks++;
            if (sv_l !== (c < 8) || sl_l !== (c == 7) ||
                so_l !== ((c < 8) ? model_bit(8'hA5, c, 1'b0) : 1'b0)) begin
                n_fail++;
                $display("FAIL lsb_a5 cycle%0d: sout/valid/last=%b%b%b required %b%b%b",
                         c, so_l, sv_l, sl_l,
                         (c < 8) ? model_bit(8'hA5, c, 1'b0) : 1'b0, (c < 8), (c == 7));
            end
            @(negedge clock);
        end
        n_checks++;
        if (n_valid != 8) begin
            n_fail++;
            $display("FAIL lsb_valid_count: %0d cycles required 8", n_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        words[0] = 8'hFF;
        words[1] = 8'h00;
        handshake_m(words[0]);
        lv_m = 1'b1;                       // held high through both words
        for (int c = 0; c < 16; c++) begin
            n_checks++;
            if (sv_m !== 1'b1 || so_m !== model_bit(words[c / 8], c % 8, 1'b1) ||
                sl_m !== (c % 8 == 7) || rdy_m !== (c % 8 == 7)) begin
                n_fail++;
                $display("FAIL b2b cycle%0d: sout/valid/last/ready=%b%b%b%b required %b1%b%b",
                         c, so_m, sv_m, sl_m, rdy_m,
                         model_bit(words[c / 8], c % 8, 1'b1), (c % 8 == 7), (c % 8 == 7));
            end
            if (c == 7)  din_m = words[1];
            if (c == 15) lv_m  = 1'b0;
            if (c < 15) @(negedge clock);
        end
        expect_idle_m("b2b");
    endtask

    task automatic test_stall();
        handshake_m(8'hA5);
        // Offer a different word while busy: must be ignored.
        din_m = 8'h3C;
        lv_m  = 1'b1;
        expect_word_m(8'hA5, "stall");
        lv_m = 1'b0;
        expect_idle_m("stall");
    endtask

    task automatic test_clear_abort();
        handshake_m(8'hA5);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (so_m !== model_bit(8'hA5, i, 1'b1) || sv_m !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_pre bit%0d: sout/valid=%b%b required %b1",
                         i, so_m, sv_m, model_bit(8'hA5, i, 1'b1));
            end
            if (i < 3) @(negedge clock);
        end
        #2 clear = 1'b0;
        #1;
        n_checks++;
        if ({so_m, sv_m, sl_m, rdy_m} !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_async: sout/valid/last/ready=%b%b%b%b required 0001",
                     so_m, sv_m, sl_m, rdy_m);
        end
        @(negedge clock);
        n_checks++;
        if ({so_m, sv_m, sl_m, rdy_m} !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_hold: sout/valid/last/ready=%b%b%b%b required 0001",
                     so_m, sv_m, sl_m, rdy_m);
        end
        clear = 1'b1;
        handshake_m(8'h81);                // first edge after release
        expect_word_m(8'h81, "after_clear");
        expect_idle_m("after_clear");
    endtask

    task automatic test_chain();
        handshake_m(8'hA5);
        for (int c = 0; c < 12; c++) begin
            if (c >= 4) begin
                n_checks++;
                if (chain[3] !== model_bit(8'hA5, c - 4, 1'b1)) begin
                    n_fail++;
                    $display("FAIL chain cycle%0d: out=%b required %b",
                             c, chain[3], model_bit(8'hA5, c - 4, 1'b1));
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        logic [7:0] word;
        int         gap;
        for (int n = 0; n < 16; n++) begin
            word = 8'($urandom);
            gap  = int'($urandom_range(0, 2));
            handshake_m(word);
            expect_word_m(word, "random");
            // gap 0 leaves the next handshake on the last-bit edge.
            for (int g = 0; g < gap; g++) expect_idle_m("random");
        end
        expect_idle_m("random_end");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        @(negedge clock);
        test_msb_a5();
        @(negedge clock);
        test_lsb_a5();
        test_back_to_back();
        @(negedge clock);
        test_stall();
        @(negedge clock);
        test_clear_abort();
        @(negedge clock);
        test_chain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer_piso.md
SERIALIZER_PISO -- requirements
Module: serializer_piso

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the MSB is sent first and 0 means the LSB is sent first.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-006 The block SHALL have port load_valid, input, 1 bit: upstream asserts that din holds a word.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block can accept din this cycle.
REQ-008 The block SHALL have port sout, output, 1 bit: the registered serial bit stream to the downstream serial consumer.
REQ-009 The block SHALL have port sout_valid, output, 1 bit: sout carries a data bit this cycle.
REQ-010 The block SHALL have port sout_last, output, 1 bit: sout carries the final bit of the current word.

Function
REQ-011 The block SHALL implement FSM states IDLE and SHIFT only.
REQ-012 Handshake SHALL occur at a rising edge where load_valid=1 and load_ready=1; din is captured at that edge; no other edge captures din.
REQ-013 load_ready SHALL be 1 in IDLE, 1 in SHIFT when the bit counter equals WIDTH-1, and 0 otherwise (combinational from registered state only, never from load_valid).
REQ-014 Latency SHALL be one cycle: after the handshake edge k, the first bit is on sout from edge k until edge k+1, and bit i is presented during cycle k+i, for i=0..WIDTH-1.
REQ-015 Bit order SHALL follow MSB_FIRST: with 1, bit i = din[WIDTH-1-i]; with 0, bit i = din[i].
REQ-016 sout_valid SHALL be 1 exactly for the WIDTH cycles a word is presented.
REQ-017 sout_last SHALL be 1 only during the cycle presenting bit WIDTH-1.
REQ-018 The bit counter SHALL be a ceil(log2(WIDTH))-bit register, cleared on handshake and incremented each SHIFT cycle, with no wrap beyond WIDTH-1.
REQ-019 Transition IDLE->SHIFT SHALL occur on handshake.
REQ-020 In SHIFT on the last bit, a handshake SHALL keep SHIFT and present the new word's bit 0 on the next cycle with zero gap; without a handshake, the state SHALL go to IDLE.
REQ-021 In IDLE, sout, sout_valid and sout_last SHALL be 0, so the downstream register is fed zeros.
REQ-022 load_valid with load_ready=0 SHALL be ignored with no state change; upstream must hold din and load_valid.
REQ-023 Changes on din or load_valid SHALL NOT disturb the word in flight outside a handshake edge.

Reset
REQ-024 While clear=0, the block SHALL force: state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, sout_last=0, load_ready=1.
REQ-025 Assertion of clear mid-word SHALL abort and discard the word immediately (asynchronously), with no partial bits emitted afterwards.
REQ-026 On clear release, the first handshake SHALL be possible at the first rising edge after release.

Structure
REQ-027 State encoding (IDLE=0, SHIFT=1) and the default WIDTH SHALL live in the shared package/header used by the serial-path blocks.
REQ-028 The block SHALL be a single module with no sub-modules; the shift register, counter and FSM are inline.
REQ-029 The block SHALL use non-blocking assignments for all sequential state, including in the reset branch.

Verification
REQ-030 With WIDTH=8, MSB_FIRST=1, din=8'hA5 and handshake at edge k, the bench SHALL check sout = 1,0,1,0,0,1,0,1 in cycles k..k+7, sout_last=1 only at k+7, then IDLE with sout=0.
REQ-031 With MSB_FIRST=0 and din=8'hA5, the bench SHALL check sout = 1,0,1,0,0,1,0,1 reversed (LSB first: 1,0,1,0,0,1,0,1 read from bit 0) and sout_valid high for exactly 8 cycles.
REQ-032 For back-to-back words 8'hFF then 8'h00, with load_valid held high, the bench SHALL check the second handshake at the last-bit edge, 16 contiguous sout_valid cycles, and sout = eight 1s then eight 0s.
REQ-033 With load_valid asserted during bits 0..6, the bench SHALL check load_ready=0, no capture, and din changing to 8'h3C not altering the output stream.
REQ-034 With clear pulsed low during bit 3 of 8'hA5, the bench SHALL check sout, sout_valid and sout_last go 0 immediately, load_ready=1, and a new word 8'h81 after release serializes correctly.
REQ-035 For an end-to-end check chained into a 4-stage serial shift register, the bench SHALL check that the register output reproduces 1,0,1,0,0,1,0,1 delayed by 4 cycles.
